// File: rtl/multicycle_sequencer_if.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer_if
//
// Purpose: bundles the control handshake between the multi-cycle sequencer
// and the RV32I datapath (instruction register, ALU, memory, register file).
//
// Signals:
//   opcode     datapath -> seq  instr[6:0] from the instruction register
//   zero       datapath -> seq  ALU zero flag
//   mem_ready  datapath -> seq  memory completes the current access
//   pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
//   mem_to_reg, alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0]
//              seq -> datapath  datapath control
//   illegal_op seq -> datapath  one-cycle pulse on unsupported opcode
//   fault      seq -> datapath  sticky memory-timeout indication
//   state[3:0] seq -> datapath  current state code (debug)
//
// Modports: master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface multicycle_sequencer_if;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic       pc_write;
   logic       pc_src;
   logic       ir_write;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       reg_write;
   logic       mem_to_reg;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic       illegal_op;
   logic       fault;
   logic [3:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_src, ir_write, iord, mem_read, mem_write,
             reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             illegal_op, fault, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_src, ir_write, iord, mem_read, mem_write,
             reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
             illegal_op, fault, state
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//
// Purpose: multi-cycle control FSM for an RV32I subset datapath (R-type, lw,
// sw, beq; optionally I-type ALU). Sequences one shared ALU and one shared
// instruction/data memory over 3-5 cycles per instruction, stalls on the
// memory ready handshake and enters a sticky FAULT state when memory fails
// to respond within TIMEOUT cycles.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; forces all enables/requests and
//               mux selects to 0 while asserted
//   bus    multicycle_sequencer_if.master (opcode/zero/mem_ready in,
//          datapath controls, illegal_op, fault, state out)
//
// Parameters:
//   TIMEOUT  consecutive mem_ready-low cycles in a memory state before FAULT
//   CNT_W    wait counter width, 2**CNT_W > TIMEOUT
//
// Build option:
//   IMM_ALU_EN  when defined, opcode 0010011 (I-type ALU) executes through
//               EXECI -> ALUWB; otherwise it is reported as illegal.
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   multicycle_sequencer_if.master bus
);

   // State codes are visible on the debug port and must not change.
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BEQ      = 4'd8;
   localparam logic [3:0] S_EXECI    = 4'd9;
   localparam logic [3:0] S_FAULT    = 4'd10;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_state;
   logic             dec_legal;
   logic [3:0]       dec_target;

   // Opcode decode used in DECODE to pick the instruction's first state.
   always_comb begin
      dec_legal  = 1'b1;
      dec_target = S_FETCH;
      case (bus.opcode)
         OP_LOAD,
         OP_STORE:  dec_target = S_MEMADR;
         OP_RTYPE:  dec_target = S_EXECR;
         OP_BRANCH: dec_target = S_BEQ;
`ifdef IMM_ALU_EN
         OP_IMM:    dec_target = S_EXECI;
`endif
         default:   dec_legal  = 1'b0;
      endcase
   end

   // States that wait on the memory handshake and are subject to timeout.
   assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                      (state_q == S_MEMWRITE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE:   state_d = dec_legal ? dec_target : S_FETCH;
         S_MEMADR:   state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
`ifdef IMM_ALU_EN
         S_EXECI:    state_d = S_ALUWB;
`endif
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_FAULT:    state_d = S_FAULT;
         default:    state_d = S_FETCH;
      endcase

      // The counter only runs while a memory state is stalled; any advance
      // (ready) or leaving a memory state clears it. Ready on the last
      // allowed cycle wins because this branch is not taken then.
      cnt_d = '0;
      if (mem_state && !bus.mem_ready) begin
         if (cnt_q == WAIT_LAST) begin
            state_d = S_FAULT;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.state = state_q;

   // Moore outputs from state, except the handshake-gated FETCH enables and
   // the zero-gated branch PC write. Reset masks every output to 0.
   always_comb begin
      bus.pc_write   = 1'b0;
      bus.pc_src     = 1'b0;
      bus.ir_write   = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.alu_src_a  = 2'b00;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = 2'b00;
      bus.illegal_op = 1'b0;
      bus.fault      = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'b10;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
               // Branch target PC+imm is precomputed into ALUOut here.
               bus.alu_src_a  = 2'b01;
               bus.alu_src_b  = 2'b01;
               bus.illegal_op = !dec_legal;
            end
            S_MEMADR: begin
               bus.alu_src_a = 2'b10;
               bus.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
               bus.mem_read = 1'b1;
               bus.iord     = 1'b1;
            end
            S_MEMWB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
               bus.mem_write = 1'b1;
               bus.iord      = 1'b1;
            end
            S_EXECR: begin
               bus.alu_src_a = 2'b10;
               bus.alu_op    = 2'b10;
            end
`ifdef IMM_ALU_EN
            S_EXECI: begin
               bus.alu_src_a = 2'b10;
               bus.alu_src_b = 2'b01;
               bus.alu_op    = 2'b10;
            end
`endif
            S_ALUWB: begin
               bus.reg_write = 1'b1;
            end
            S_BEQ: begin
               bus.alu_src_a = 2'b10;
               bus.alu_op    = 2'b01;
               bus.pc_src    = 1'b1;
               bus.pc_write  = bus.zero;
            end
            S_FAULT: begin
               bus.fault = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Self-checking bench: directed scenarios followed by randomized traffic.
// A behavioural model tracks each instruction as a list of remaining steps
// plus a stall tally, and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;
   localparam int TIMEOUT = 15;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] IMM = 7'b0010011;
   localparam logic [6:0] BAD = 7'b1111111;

   logic clk;
   logic reset;
   multicycle_sequencer_if bus();

   multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: current state code, stall tally, remaining steps of instruction.
   int m_st;
   int m_wait;
   int rcp[$];

   // Observations from the most recent cycle.
   logic [3:0] o_state;
   logic       o_pcw, o_irw, o_regw, o_memw, o_ill, o_fault;

   function automatic bit is_legal(input logic [6:0] op);
`ifdef IMM_ALU_EN
      return (op == LW) || (op == SW) || (op == RT) || (op == BQ) || (op == IMM);
`else
      return (op == LW) || (op == SW) || (op == RT) || (op == BQ);
`endif
   endfunction

   // {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
   //  mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, fault}
   function automatic logic [15:0] exp_outs(input int st, input logic r,
                                            input logic rdy, input logic z,
                                            input logic [6:0] op);
      logic pcw, pcs, irw, ior, mr, mw, rw, m2r, ill, flt;
      logic [1:0] a, b, aop;
      {pcw, pcs, irw, ior, mr, mw, rw, m2r, ill, flt} = '0;
      a = 2'b00; b = 2'b00; aop = 2'b00;
      if (!r) begin
         case (st)
            0:  begin mr = 1; b = 2'b10; irw = rdy; pcw = rdy; end
            1:  begin a = 2'b01; b = 2'b01; ill = !is_legal(op); end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  begin mr = 1; ior = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; ior = 1; end
            6:  begin a = 2'b10; aop = 2'b10; end
            7:  begin rw = 1; end
            8:  begin a = 2'b10; aop = 2'b01; pcs = 1; pcw = z; end
            9:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            10: begin flt = 1; end
            default: ;
         endcase
      end
      return {pcw, pcs, irw, ior, mr, mw, rw, m2r, a, b, aop, ill, flt};
   endfunction

   // Move to the next step of the current instruction.
   task automatic advance(input logic [6:0] op);
      if (m_st == 0) begin
         m_st = 1;
      end else if (m_st == 1) begin
         rcp.delete();
         if (is_legal(op)) begin
            case (op)
               LW:      begin rcp.push_back(2); rcp.push_back(3); rcp.push_back(4); end
               SW:      begin rcp.push_back(2); rcp.push_back(5); end
               RT:      begin rcp.push_back(6); rcp.push_back(7); end
               BQ:      begin rcp.push_back(8); end
               default: begin rcp.push_back(9); rcp.push_back(7); end
            endcase
         end
         m_st = (rcp.size() > 0) ? rcp.pop_front() : 0;
      end else begin
         m_st = (rcp.size() > 0) ? rcp.pop_front() : 0;
      end
   endtask

   task automatic model_step(input logic r, input logic rdy, input logic [6:0] op);
      if (r) begin
         m_st = 0; m_wait = 0; rcp.delete();
      end else if (m_st == 10) begin
         m_st = 10;
      end else if (m_st == 0 || m_st == 3 || m_st == 5) begin
         if (rdy) begin
            m_wait = 0;
            advance(op);
         end else if (m_wait == TIMEOUT - 1) begin
            m_st = 10; m_wait = 0;
         end else begin
            m_wait++;
         end
      end else begin
         advance(op);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check all outputs against the model, advance.
   task automatic cyc(input logic r, input logic rdy, input logic z, input logic [6:0] op);
      logic [15:0] ev, av;
      reset = r; bus.mem_ready = rdy; bus.zero = z; bus.opcode = op;
      #1;
      ev = exp_outs(m_st, r, rdy, z, op);
      av = {bus.pc_write, bus.pc_src, bus.ir_write, bus.iord, bus.mem_read,
            bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.illegal_op, bus.fault};
      chk("outs", {16'd0, av}, {16'd0, ev});
      chk("state", {28'd0, bus.state}, 32'(m_st));
      o_state = bus.state; o_pcw = bus.pc_write; o_irw = bus.ir_write;
      o_regw = bus.reg_write; o_memw = bus.mem_write; o_ill = bus.illegal_op;
      o_fault = bus.fault;
      model_step(r, rdy, op);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lw_seq[5] = '{0, 1, 2, 3, 4};
      int mw_cnt, rw_cnt, burst;
      logic [6:0] cur_op;
      logic [6:0] ops[7] = '{LW, SW, RT, BQ, IMM, BAD, 7'b0000000};

      // Initial reset; state is unknown until the first edge.
      reset = 1'b1; bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.opcode = LW;
      @(posedge clk); #1;
      m_st = 0; m_wait = 0;
      cyc(1, 1, 0, LW);
      chk("rst_pcw", {31'd0, o_pcw}, 0);
      chk("rst_st", {28'd0, o_state}, 0);

      // lw with memory always ready.
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 0, LW);
         chk("lw_st", {28'd0, o_state}, 32'(lw_seq[i]));
         chk("lw_regw", {31'd0, o_regw}, (i == 4) ? 1 : 0);
      end
      chk("lw_end", {28'd0, bus.state}, 0);

      // Reset for two cycles while stalled in MEMREAD.
      for (int i = 0; i < 3; i++) cyc(0, 1, 0, LW);
      cyc(0, 0, 0, LW);
      chk("mr_st", {28'd0, o_state}, 3);
      for (int i = 0; i < 2; i++) begin
         cyc(1, 1, 0, LW);
         chk("rst_irw", {31'd0, o_irw}, 0);
      end
      cyc(0, 1, 0, LW);
      chk("rel_st", {28'd0, o_state}, 0);
      chk("rel_pcw", {31'd0, o_pcw}, 1);
      chk("rel_irw", {31'd0, o_irw}, 1);
      chk("rel_flt", {31'd0, o_fault}, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, LW);

      // beq taken, then not taken.
      for (int t = 0; t < 2; t++) begin
         for (int i = 0; i < 3; i++) cyc(0, 1, (t == 0), BQ);
         chk("beq_st", {28'd0, o_state}, 8);
         chk("beq_pcw", {31'd0, o_pcw}, (t == 0) ? 1 : 0);
         chk("beq_end", {28'd0, bus.state}, 0);
      end

      // sw with three stall cycles in MEMWRITE.
      mw_cnt = 0; rw_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(0, (i < 3 || i == 6), 0, SW);
         mw_cnt += int'(o_memw);
         rw_cnt += int'(o_regw);
      end
      chk("sw_memw", 32'(mw_cnt), 4);
      chk("sw_regw", 32'(rw_cnt), 0);
      chk("sw_end", {28'd0, bus.state}, 0);

      // Timeout in FETCH, sticky until reset.
      for (int i = 0; i < TIMEOUT; i++) cyc(0, 0, 0, LW);
      chk("to_st", {28'd0, bus.state}, 10);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, LW);
         chk("to_flt", {31'd0, o_fault}, 1);
      end
      cyc(1, 0, 0, LW);
      chk("to_clr", {28'd0, bus.state}, 0);

      // Ready arrives on the last allowed cycle: no fault.
      for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 0, IMM);
      cyc(0, 1, 0, IMM);
      chk("late_pcw", {31'd0, o_pcw}, 1);
      chk("late_st", {28'd0, bus.state}, 1);

      // I-type ALU opcode in DECODE.
      cyc(0, 1, 0, IMM);
`ifdef IMM_ALU_EN
      chk("imm_ill", {31'd0, o_ill}, 0);
      chk("imm_st", {28'd0, bus.state}, 9);
      cyc(0, 1, 0, IMM);
      cyc(0, 1, 0, IMM);
`else
      chk("imm_ill", {31'd0, o_ill}, 1);
`endif
      chk("imm_end", {28'd0, bus.state}, 0);

      // Unsupported opcode.
      cyc(0, 1, 0, BAD);
      cyc(0, 1, 0, BAD);
      chk("bad_ill", {31'd0, o_ill}, 1);
      chk("bad_end", {28'd0, bus.state}, 0);

      // Randomized traffic against the model.
      cur_op = LW; burst = 0;
      for (int n = 0; n < 2000; n++) begin
         logic r, rdy;
         if (m_st == 0) begin
            cur_op = ops[$urandom_range(0, 6)];
            if (cur_op == 7'b0000000) cur_op = 7'($urandom);
         end
         if (burst == 0 && $urandom_range(0, 150) == 0) burst = $urandom_range(10, 20);
         if (burst > 0) begin
            rdy = 1'b0; burst--;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
         end
         r = ($urandom_range(0, 99) == 0) || (m_st == 10 && $urandom_range(0, 4) == 0);
         cyc(r, rdy, 1'($urandom), cur_op);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the RV32I subset datapath: R-type, lw, sw and beq, with I-type ALU as an option.
- Replaces the single-cycle opcode decoder.
- Sequences one shared ALU and one shared instruction/data memory over 3-5 cycles per instruction.
- Stalls on a memory ready handshake and enters a sticky fault state on memory timeout.

Parameters:
TIMEOUT, 15, maximum consecutive cycles with mem_ready low in any memory state before fault (1..255)
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  7  instr[6:0] from instruction register, valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  PC load enable
pc_src  out  1  0 = ALU result, 1 = ALUOut register
ir_write  out  1  instruction register load
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write
mem_to_reg  out  1  writeback source: 1 = memory data register, 0 = ALUOut
alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = const 4
alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
illegal_op  out  1  one-cycle pulse on unsupported opcode
fault  out  1  sticky memory-timeout indication
state  out  4  current state encoding (debug)

Behaviour:
- Clock and reset: single clk domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- On reset: state=FETCH(0), wait counter=0, fault=0. While reset=1, all enables and requests are forced 0 (pc_write, ir_write, reg_write, mem_read, mem_write), illegal_op=0, and muxes select 00.
- Reset wins over every transition, including mid-instruction and in FAULT.
- Outputs are combinational from state. Handshake-gated outputs also depend on mem_ready; pc_write in BEQ also depends on zero. Unlisted outputs are 0.
- State encodings (fixed, appear on the state port): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, BEQ 8, EXECI 9, FAULT 10.

Per-state outputs and transitions:
- FETCH:
  - mem_read=1, iord=0, alu_src_a=00, alu_src_b=10, alu_op=00.
  - ir_write=pc_write=mem_ready, pc_src=0.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 1100011 -> BEQ; 0010011 -> EXECI (macro only).
  - Any other opcode: illegal_op=1 this cycle, -> FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Opcode 0000011 -> MEMREAD; otherwise -> MEMWRITE.
- MEMREAD: mem_read=1, iord=1. mem_ready -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1 -> FETCH.
- MEMWRITE: mem_write=1, iord=1. mem_ready -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero -> FETCH.
- FAULT: fault=1, all enables 0. Stays until reset.

Latency: lw 5 cycles, sw 4, R-type 4, beq 3, illegal 2; each memory state adds one cycle per mem_ready-low cycle.

Wait counter and timeout:
- Applies in FETCH, MEMREAD and MEMWRITE.
- mem_ready=0: counter increments.
- mem_ready=1: counter clears and the state advances.
- Counter==TIMEOUT-1 with mem_ready=0: next state FAULT, no request issued afterwards.
- mem_ready=1 on the same cycle the counter reaches TIMEOUT-1: ready wins, no fault.
- Counter clears on every state change.
- Counter never wraps (TIMEOUT < 2^CNT_W).

mem_ready outside memory states is ignored.

Optional Feature:
IMM_ALU_EN
- Defined: opcode 0010011 decodes to EXECI (alu_src_a=10, alu_src_b=01, alu_op=10), then ALUWB. addi takes 4 cycles.
- Undefined: EXECI is unreachable; 0010011 is treated as illegal (illegal_op pulse, return to FETCH). State code 9 is never produced.

Test Plan:
- Reset for 2 cycles mid-MEMREAD, then release with mem_ready=1 -> state=0 on the cycle after release; pc_write=ir_write=1 only after reset=0; fault=0.
- lw (opcode 0000011), mem_ready always 1 -> states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. Exactly 5 cycles.
- beq (1100011) with zero=1, then again with zero=0 -> state 8 has alu_op=01 and pc_src=1. pc_write=1 in the first case, 0 in the second. Back to FETCH after 3 cycles.
- sw with mem_ready held low for 3 cycles in MEMWRITE -> mem_write=1 for 4 cycles, reg_write never 1, FETCH follows.
- TIMEOUT=15, mem_ready held 0 in FETCH -> state=10 after 15 cycles, fault=1 until reset. A separate run asserting mem_ready on the 15th cycle -> DECODE, no fault.
- opcode 0010011 -> with IMM_ALU_EN: states 0,1,9,7,0. Without: illegal_op pulses one cycle in DECODE, next state 0. Opcode 1111111 -> illegal_op pulse in both builds.
